// File: rtl/uart_vector_printer.sv
// Prints a value memory as comma-separated signed decimal over a byte-wide UART TX, CR LF terminated.
// Define UART_VECTOR_PRINTER_HEX_EN to also accept "x", which prints each value as 0x-prefixed uppercase hex.
module uart_vector_printer #(
   parameter int         DATA_WIDTH   = 32,
   parameter int         NUM_VALUES   = 100,
   parameter int         ADDR_WIDTH   = 7,
   parameter int         DIGITS       = 10,
   parameter logic [7:0] TRIGGER_CHAR = 8'h70,
   parameter logic [7:0] ABORT_CHAR   = 8'h1B,
   parameter logic [7:0] SEP_CHAR     = 8'h2C
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  new_rx_data,
   output logic [7:0]            tx_data,
   output logic                  new_tx_data,
   input  logic                  tx_busy,
   output logic [ADDR_WIDTH-1:0] val_addr,
   input  logic [DATA_WIDTH-1:0] val_data,
   output logic                  busy,
   output logic                  done
);

   localparam int HEX_DIGITS = (DATA_WIDTH + 3) / 4;
   localparam int BCD_W      = DIGITS * 4;
   localparam int SH_W       = (DATA_WIDTH + 1 > HEX_DIGITS * 4) ? DATA_WIDTH + 1 : HEX_DIGITS * 4;
   localparam int MAX_DIG    = (DIGITS > HEX_DIGITS) ? DIGITS : HEX_DIGITS;
   localparam int DIG_W      = $clog2(MAX_DIG + 1);
   localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_VALUES - 1);

   typedef enum logic [3:0] {
      IDLE, FETCH, CONVERT, SIGN, DIGIT, SEP, CR, LF, GAP
   } state_t;

   state_t                state_q, state_d;
   state_t                ret_q, ret_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  fetch_ph_q, fetch_ph_d;
   logic                  neg_q, neg_d;
   logic                  pfx_q, pfx_d;
   logic                  abort_q, abort_d;
   logic [SH_W-1:0]       sh_q, sh_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIG_W-1:0]      dig_q, dig_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  new_tx_q, new_tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [DATA_WIDTH:0]   val_ext, mag;
   logic [BCD_W-1:0]      bcd_adj;
   logic [DIG_W-1:0]      lead_dig;
   logic [3:0]            dec_nib;
   logic [7:0]            digit_char;
   logic                  hex_mode, start_hex;
   logic                  terminating, abort_hit, abort_pend;

   assign tx_data     = tx_data_q;
   assign new_tx_data = new_tx_q;
   assign val_addr    = idx_q;
   assign busy        = busy_q;
   assign done        = done_q;

   // Sign-extend before negating so the most negative input still yields its true magnitude.
   assign val_ext = {val_data[DATA_WIDTH-1], val_data};
   assign mag     = val_ext[DATA_WIDTH] ? -val_ext : val_ext;
   assign dec_nib = bcd_q[{dig_q, 2'b00} +: 4];

`ifdef UART_VECTOR_PRINTER_HEX_EN
   localparam logic [7:0] HEX_CHAR = 8'h78;
   logic       hex_q, hex_d;
   logic [3:0] hex_nib;

   assign hex_mode   = hex_q;
   assign start_hex  = new_rx_data && (rx_data == HEX_CHAR);
   assign hex_nib    = sh_q[{dig_q, 2'b00} +: 4];
   assign digit_char = !hex_q              ? 8'h30 + {4'h0, dec_nib} :
                       (hex_nib < 4'd10)   ? 8'h30 + {4'h0, hex_nib} :
                                             8'h37 + {4'h0, hex_nib};

   always_comb begin
      hex_d = hex_q;
      if (state_q == IDLE) hex_d = start_hex;
   end

   always_ff @(posedge clk) begin
      if (rst) hex_q <= 1'b0;
      else     hex_q <= hex_d;
   end
`else
   assign hex_mode   = 1'b0;
   assign start_hex  = 1'b0;
   assign digit_char = 8'h30 + {4'h0, dec_nib};
`endif

   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      lead_dig = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] != 4'd0) lead_dig = DIG_W'(i);
      end
   end

   // Once CR is committed the pass is already ending, so a late ESC has nothing to cancel.
   assign terminating = (state_q == CR) || (state_q == LF) ||
                        ((state_q == GAP) && ((ret_q == LF) || (ret_q == IDLE)));
   assign abort_hit   = new_rx_data && (rx_data == ABORT_CHAR) && busy_q && !terminating;
   assign abort_pend  = abort_q || abort_hit;

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      idx_d      = idx_q;
      fetch_ph_d = fetch_ph_q;
      neg_d      = neg_q;
      pfx_d      = pfx_q;
      sh_d       = sh_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      dig_d      = dig_q;
      tx_data_d  = tx_data_q;
      new_tx_d   = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      abort_d    = abort_q || abort_hit;

      if ((state_q == SIGN || state_q == DIGIT || state_q == SEP) && abort_pend && tx_busy) begin
         state_d = CR;
      end else begin
         case (state_q)
            IDLE: begin
               if (new_rx_data && ((rx_data == TRIGGER_CHAR) || start_hex)) begin
                  idx_d      = '0;
                  busy_d     = 1'b1;
                  abort_d    = 1'b0;
                  fetch_ph_d = 1'b0;
                  state_d    = FETCH;
               end
            end
            FETCH: begin
               if (abort_pend) begin
                  state_d = CR;
               end else if (!fetch_ph_q) begin
                  fetch_ph_d = 1'b1;
               end else begin
                  fetch_ph_d = 1'b0;
                  neg_d      = !hex_mode && val_data[DATA_WIDTH-1];
                  sh_d       = hex_mode ? SH_W'(val_data) : SH_W'(mag);
                  bcd_d      = '0;
                  cnt_d      = '0;
                  pfx_d      = 1'b0;
                  dig_d      = DIG_W'(HEX_DIGITS - 1);
                  state_d    = hex_mode ? SIGN : CONVERT;
               end
            end
            CONVERT: begin
               if (abort_pend) begin
                  state_d = CR;
               end else if (cnt_q != CNT_W'(DATA_WIDTH)) begin
                  bcd_d = {bcd_adj[BCD_W-2:0], sh_q[DATA_WIDTH-1]};
                  sh_d  = sh_q << 1;
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  dig_d   = lead_dig;
                  state_d = neg_q ? SIGN : DIGIT;
               end
            end
            SIGN: begin
               if (!tx_busy) begin
                  new_tx_d  = 1'b1;
                  state_d   = GAP;
                  // Hex mode reuses this state twice for the "0x" prefix.
                  tx_data_d = !hex_mode ? 8'h2D : (pfx_q ? 8'h78 : 8'h30);
                  ret_d     = (hex_mode && !pfx_q) ? SIGN : DIGIT;
                  pfx_d     = 1'b1;
               end
            end
            DIGIT: begin
               if (!tx_busy) begin
                  new_tx_d  = 1'b1;
                  state_d   = GAP;
                  tx_data_d = digit_char;
                  if (dig_q != '0) begin
                     dig_d = dig_q - DIG_W'(1);
                     ret_d = DIGIT;
                  end else begin
                     ret_d = (idx_q == LAST_IDX) ? CR : SEP;
                  end
               end
            end
            SEP: begin
               if (!tx_busy) begin
                  new_tx_d  = 1'b1;
                  state_d   = GAP;
                  tx_data_d = SEP_CHAR;
                  idx_d     = idx_q + ADDR_WIDTH'(1);
                  ret_d     = FETCH;
               end
            end
            CR: begin
               if (!tx_busy) begin
                  new_tx_d  = 1'b1;
                  state_d   = GAP;
                  tx_data_d = 8'h0D;
                  ret_d     = LF;
               end
            end
            LF: begin
               if (!tx_busy) begin
                  new_tx_d  = 1'b1;
                  state_d   = GAP;
                  tx_data_d = 8'h0A;
                  ret_d     = IDLE;
               end
            end
            GAP: begin
               if (abort_pend && !terminating) begin
                  state_d = CR;
               end else begin
                  state_d    = ret_q;
                  fetch_ph_d = 1'b0;
                  if (ret_q == IDLE) begin
                     busy_d  = 1'b0;
                     done_d  = !abort_q;
                     abort_d = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ret_q      <= IDLE;
         idx_q      <= '0;
         fetch_ph_q <= 1'b0;
         neg_q      <= 1'b0;
         pfx_q      <= 1'b0;
         abort_q    <= 1'b0;
         sh_q       <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         dig_q      <= '0;
         tx_data_q  <= '0;
         new_tx_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         idx_q      <= idx_d;
         fetch_ph_q <= fetch_ph_d;
         neg_q      <= neg_d;
         pfx_q      <= pfx_d;
         abort_q    <= abort_d;
         sh_q       <= sh_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         dig_q      <= dig_d;
         tx_data_q  <= tx_data_d;
         new_tx_q   <= new_tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_vector_printer.sv
// Bench for uart_vector_printer: three instances (3, 1 and 100 values) against a string-building reference.
module tb_uart_vector_printer;

   localparam int NI       = 3;
   localparam int BUSY_CYC = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0]  rx_data  [NI];
   logic        new_rx   [NI];
   logic [7:0]  tx_data  [NI];
   logic        new_tx   [NI];
   logic [6:0]  val_addr [NI];
   logic [31:0] val_data [NI];
   logic        busy     [NI];
   logic        done     [NI];
   logic [31:0] mem      [NI][128];
   int          busy_cnt [NI];
   bit          busy_mode[NI];
   string       cap      [NI];
   int          done_cnt [NI];
   int          viol     [NI];
   logic        prev_new [NI];

   int    n_cmp = 0;
   int    n_err = 0;
   string crlf;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int NV = (g == 0) ? 3 : ((g == 1) ? 1 : 100);
      uart_vector_printer #(.NUM_VALUES(NV)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .rx_data    (rx_data[g]),
         .new_rx_data(new_rx[g]),
         .tx_data    (tx_data[g]),
         .new_tx_data(new_tx[g]),
         .tx_busy    (busy_mode[g] && (busy_cnt[g] != 0)),
         .val_addr   (val_addr[g]),
         .val_data   (val_data[g]),
         .busy       (busy[g]),
         .done       (done[g])
      );
   end

   // Synchronous-read value memory and a UART whose busy rises the cycle after each strobe.
   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         val_data[g] <= mem[g][val_addr[g]];
         if (new_tx[g] === 1'b1)  busy_cnt[g] <= BUSY_CYC;
         else if (busy_cnt[g] > 0) busy_cnt[g] <= busy_cnt[g] - 1;
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (new_tx[g] === 1'b1) begin
            cap[g] = $sformatf("%s%c", cap[g], tx_data[g]);
            if ((busy_mode[g] && busy_cnt[g] != 0) || prev_new[g] === 1'b1) viol[g]++;
         end
         if (done[g] === 1'b1) begin
            done_cnt[g]++;
            if (busy[g] !== 1'b0) viol[g]++;
         end
         prev_new[g] = new_tx[g];
      end
   end

   function automatic string vis(input string s);
      string r = "";
      for (int i = 0; i < s.len(); i++) begin
         logic [7:0] c = s[i];
         if (c >= 8'd32 && c < 8'd127) r = $sformatf("%s%c", r, c);
         else                          r = $sformatf("%s<%02h>", r, c);
      end
      return r;
   endfunction

   function automatic string window(input string s, input int p);
      int e = p + 15;
      if (e > s.len() - 1) e = s.len() - 1;
      if (p > e) return "";
      return vis(s.substr(p, e));
   endfunction

   function automatic string exp_dec(input int g, input int n);
      string s = "";
      for (int i = 0; i < n; i++) begin
         s = {s, $sformatf("%0d", $signed(mem[g][i]))};
         if (i != n - 1) s = {s, ","};
      end
      return {s, crlf};
   endfunction

   function automatic logic [31:0] rnd_val();
      logic [31:0] v;
      case ($urandom_range(0, 3))
         0:       v = 32'($urandom_range(0, 9));
         1:       v = -32'($urandom_range(1, 99999));
         2:       v = $urandom;
         default: begin
            case ($urandom_range(0, 3))
               0:       v = 32'h8000_0000;
               1:       v = 32'h7FFF_FFFF;
               2:       v = 32'h0000_0000;
               default: v = 32'hFFFF_FFFF;
            endcase
         end
      endcase
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_str(input string tag, input string obs, input string exp);
      int p = 0;
      n_cmp++;
      assert (obs == exp) else begin
         n_err++;
         while (p < obs.len() && p < exp.len() && obs[p] == exp[p]) p++;
         $error("FAIL %s: observed len %0d expected len %0d, differ at %0d: observed '%s' expected '%s'",
                tag, obs.len(), exp.len(), p, window(obs, p), window(exp, p));
      end
   endtask

   task automatic send_byte(input int g, input logic [7:0] b);
      rx_data[g] = b;
      new_rx[g]  = 1'b1;
      tick();
      new_rx[g]  = 1'b0;
   endtask

   task automatic start(input int g, input logic [7:0] b);
      cap[g] = "";
      send_byte(g, b);
   endtask

   task automatic wait_idle(input int g, input int budget, input string tag);
      int k = 0;
      while (busy[g] !== 1'b0 && k < budget) begin
         tick();
         k++;
      end
      chk(tag, busy[g], 1'b0);
      repeat (3) tick();
   endtask

   task automatic wait_chars(input int g, input int n, input int budget, input string tag);
      int k = 0;
      while (cap[g].len() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, cap[g].len() >= n, 1'b1);
   endtask

   initial begin
      int    d0, snap;
      string exp_s;
      crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
      rst  = 1'b1;
      for (int g = 0; g < NI; g++) begin
         rx_data[g]   = 8'h00;
         new_rx[g]    = 1'b0;
         busy_mode[g] = 1'b0;
         prev_new[g]  = 1'b0;
         cap[g]       = "";
         done_cnt[g]  = 0;
         viol[g]      = 0;
         busy_cnt[g]  = 0;
         for (int a = 0; a < 128; a++) mem[g][a] = 32'h0;
      end
      repeat (3) tick();
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("reset tx_data[%0d]", g), tx_data[g], 8'h00);
         chk($sformatf("reset new_tx[%0d]", g), new_tx[g], 1'b0);
         chk($sformatf("reset val_addr[%0d]", g), val_addr[g], 7'h00);
         chk($sformatf("reset busy[%0d]", g), busy[g], 1'b0);
         chk($sformatf("reset done[%0d]", g), done[g], 1'b0);
      end
      rst = 1'b0;
      tick();

      // Three values, UART never busy.
      mem[0][0] = 32'd5;
      mem[0][1] = 32'hFFFF_FFD1;
      mem[0][2] = 32'd0;
      start(0, 8'h70);
      wait_idle(0, 2000, "dec3 idle");
      chk_str("dec3 bytes", cap[0], {"5,-47,0", crlf});
      chk("dec3 done count", done_cnt[0], 1);

      // Same pass with a slow UART.
      busy_mode[0] = 1'b1;
      start(0, 8'h70);
      wait_idle(0, 4000, "dec3 slow idle");
      chk_str("dec3 slow bytes", cap[0], {"5,-47,0", crlf});
      chk("dec3 slow done count", done_cnt[0], 2);
      chk("dec3 handshake violations", viol[0], 0);

      // Single-value extremes.
      mem[1][0] = 32'h8000_0000;
      start(1, 8'h70);
      wait_idle(1, 2000, "min idle");
      chk_str("most negative", cap[1], {"-2147483648", crlf});
      mem[1][0] = 32'h7FFF_FFFF;
      start(1, 8'h70);
      wait_idle(1, 2000, "max idle");
      chk_str("most positive", cap[1], {"2147483647", crlf});
      chk("single done count", done_cnt[1], 2);

      // Hundred values, with a repeated trigger mid-pass.
      for (int i = 0; i < 100; i++) mem[2][i] = 32'(i - 50);
      start(2, 8'h70);
      wait_chars(2, 40, 3000, "vec100 progress");
      send_byte(2, 8'h70);
      wait_idle(2, 20000, "vec100 idle");
      chk_str("vec100 bytes", cap[2], exp_dec(2, 100));
      chk("vec100 done count", done_cnt[2], 1);

      // ESC just after the third strobe.
      d0 = done_cnt[0];
      start(0, 8'h70);
      wait_chars(0, 3, 2000, "abort progress");
      send_byte(0, 8'h1B);
      wait_idle(0, 2000, "abort idle");
      chk_str("abort bytes", cap[0], {"5,-", crlf});
      chk("abort no done", done_cnt[0], d0);
      start(0, 8'h70);
      wait_idle(0, 4000, "after abort idle");
      chk_str("after abort bytes", cap[0], {"5,-47,0", crlf});
      chk("after abort done", done_cnt[0], d0 + 1);

      // Reset mid-pass stops all further strobes.
      start(2, 8'h70);
      wait_chars(2, 20, 3000, "reset progress");
      rst  = 1'b1;
      snap = cap[2].len();
      repeat (2) tick();
      rst = 1'b0;
      repeat (60) tick();
      chk("reset mid-pass strobes", cap[2].len(), snap);
      chk("reset mid-pass busy", busy[2], 1'b0);

      // Hex request.
      mem[1][0] = 32'hFFFF_FFFF;
      d0 = done_cnt[1];
`ifdef UART_VECTOR_PRINTER_HEX_EN
      start(1, 8'h78);
      wait_idle(1, 2000, "hex idle");
      chk_str("hex all ones", cap[1], {"0xFFFFFFFF", crlf});
      mem[1][0] = $urandom;
      exp_s = {$sformatf("0x%08X", mem[1][0]), crlf};
      start(1, 8'h78);
      wait_idle(1, 2000, "hex rnd idle");
      chk_str("hex random", cap[1], exp_s);
      chk("hex done count", done_cnt[1], d0 + 2);
`else
      start(1, 8'h78);
      repeat (60) tick();
      chk("x ignored no tx", cap[1].len(), 0);
      chk("x ignored busy", busy[1], 1'b0);
      chk("x ignored done", done_cnt[1], d0);
`endif

      // Randomised passes against the string model.
      for (int r = 0; r < 4; r++) begin
         busy_mode[0] = 1'($urandom_range(0, 1));
         for (int i = 0; i < 3; i++) mem[0][i] = rnd_val();
         exp_s = exp_dec(0, 3);
         start(0, 8'h70);
         wait_idle(0, 4000, $sformatf("rnd3 idle %0d", r));
         chk_str($sformatf("rnd3 bytes %0d", r), cap[0], exp_s);
      end
      busy_mode[2] = 1'b1;
      for (int i = 0; i < 100; i++) mem[2][i] = rnd_val();
      exp_s = exp_dec(2, 100);
      start(2, 8'h70);
      wait_idle(2, 40000, "rnd100 idle");
      chk_str("rnd100 bytes", cap[2], exp_s);
      for (int g = 0; g < NI; g++) chk($sformatf("handshake violations[%0d]", g), viol[g], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
